regfile_write_arbiter: RTL and testbench

- Shares the register file's single synchronous write port between NREQ writeback requesters (e.g. ALU, load unit, multiplier) using round-robin arbitration.
- Drives the register file's RegWrite / WriteRegister / WriteData from a registered output stage.
- Keeps a 32-entry destination scoreboard so issue logic can tell when a source register has an outstanding write.
- Sits between the execution units and the register file.

---
 rtl/regfile_write_arbiter_if.sv | 31 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Bundle between the writeback requesters / issue logic and the register-file
// write arbiter.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [NREQ-1:0]        Req;
    logic [NREQ*ADDR_W-1:0] ReqAddr;
    logic [NREQ*DATA_W-1:0] ReqData;
    logic [NREQ-1:0]        Grant;
    logic                   Reserve;
    logic [ADDR_W-1:0]      ReserveAddr;
    logic [ADDR_W-1:0]      ReadAddr1;
    logic [ADDR_W-1:0]      ReadAddr2;
    logic                   Busy1;
    logic                   Busy2;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WriteRegister;
    logic [DATA_W-1:0]      WriteData;

    modport master (
        output Req, ReqAddr, ReqData, Reserve, ReserveAddr, ReadAddr1, ReadAddr2,
        input  Grant, Busy1, Busy2, RegWrite, WriteRegister, WriteData
    );

    modport slave (
        input  Req, ReqAddr, ReqData, Reserve, ReserveAddr, ReadAddr1, ReadAddr2,
        output Grant, Busy1, Busy2, RegWrite, WriteRegister, WriteData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// registered write stage and a per-register outstanding-write scoreboard.
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREGS = 1 << ADDR_W;

    // Returns {found, index} of the first request after 'last', wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            res = req[idx] ? {1'b1, IDX_W'(idx)} : res;
        end
        return res;
    endfunction

    logic [IDX_W-1:0]  r_last;
    logic              r_regwrite;
    logic [ADDR_W-1:0] r_wreg;
    logic [DATA_W-1:0] r_wdata;
    logic [NREGS-1:0]  r_busy;

    logic [IDX_W:0]    w_pick;
    logic [IDX_W-1:0]  w_idx;
    logic              w_xfer;
    logic [NREQ-1:0]   w_grant;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [NREGS-1:0]  w_busy_nxt;
    logic              w_busy1;
    logic              w_busy2;

    // Arbitration; nothing is granted while reset is held
    always_comb begin
        w_pick = rr_pick(bus.Req, r_last);
        w_idx  = w_pick[IDX_W-1:0];
        w_xfer = w_pick[IDX_W] & Reset_n;
        if (w_xfer) begin
            w_grant = NREQ'(1'b1) << w_idx;
        end else begin
            w_grant = '0;
        end
    end

    // Winner's address and data
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_addr = w_grant[i] ? bus.ReqAddr[i*ADDR_W +: ADDR_W] : w_addr;
            w_data = w_grant[i] ? bus.ReqData[i*DATA_W +: DATA_W] : w_data;
        end
    end

    // Scoreboard next state: a same-edge reserve beats the clearing transfer
    always_comb begin
        w_busy_nxt = r_busy;
        for (int a = 1; a < NREGS; a++) begin
            w_busy_nxt[a] = (bus.Reserve && (bus.ReserveAddr == ADDR_W'(a))) ||
                            (r_busy[a] && !(w_xfer && (w_addr == ADDR_W'(a))));
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Write stage, round-robin pointer and scoreboard state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last     <= IDX_W'(NREQ - 1);
            r_regwrite <= 1'b0;
            r_wreg     <= '0;
            r_wdata    <= '0;
            r_busy     <= '0;
        end else begin
            r_regwrite <= w_xfer && (w_addr != '0);
            if (w_xfer) begin
                r_last  <= w_idx;
                r_wreg  <= w_addr;
                r_wdata <= w_data;
            end else begin
                r_last  <= r_last;
                r_wreg  <= r_wreg;
                r_wdata <= r_wdata;
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Hazard probes also cover the write sitting in the output stage
    always_comb begin
        w_busy1 = (bus.ReadAddr1 != '0) &&
                  (r_busy[bus.ReadAddr1] || (r_regwrite && (r_wreg == bus.ReadAddr1)));
        w_busy2 = (bus.ReadAddr2 != '0) &&
                  (r_busy[bus.ReadAddr2] || (r_regwrite && (r_wreg == bus.ReadAddr2)));
    end

    assign bus.Grant         = w_grant;
    assign bus.Busy1         = w_busy1;
    assign bus.Busy2         = w_busy2;
    assign bus.RegWrite      = r_regwrite;
    assign bus.WriteRegister = r_wreg;
    assign bus.WriteData     = r_wdata;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized handshake traffic compared each cycle against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

    regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    logic [ADDR_W-1:0] ra [NREQ];
    logic [DATA_W-1:0] rd [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.ReqAddr[i*ADDR_W +: ADDR_W] = ra[i];
            bus.ReqData[i*DATA_W +: DATA_W] = rd[i];
        end
    end

    int total;
    int bad;

    // behavioural model state
    int                m_last;
    bit                m_rw;
    logic [ADDR_W-1:0] m_wreg;
    logic [DATA_W-1:0] m_wdata;
    bit                m_busy [32];
    int                last_gnt;
    int                waitc [NREQ];

    // outputs sampled on the most recent step
    logic [NREQ-1:0]   s_grant;
    logic              s_rw;
    logic [ADDR_W-1:0] s_wreg;
    logic [DATA_W-1:0] s_wdata;
    logic              s_b1;
    logic              s_b2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = NREQ - 1;
        m_rw    = 1'b0;
        m_wreg  = '0;
        m_wdata = '0;
        for (int a = 0; a < 32; a++) m_busy[a] = 1'b0;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit exp_busy(input logic [ADDR_W-1:0] a);
        return (a != '0) && (m_busy[a] || (m_rw && (m_wreg == a)));
    endfunction

    // One clock: compare after the inputs settle, then advance the model across the edge.
    task automatic step();
        int              g;
        logic [NREQ-1:0] eg;
        #1;
        if (!Reset_n) model_reset();
        g  = Reset_n ? pick(bus.Req, m_last) : -1;
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        s_grant = bus.Grant;
        s_rw    = bus.RegWrite;
        s_wreg  = bus.WriteRegister;
        s_wdata = bus.WriteData;
        s_b1    = bus.Busy1;
        s_b2    = bus.Busy2;
        chk("grant",    64'(s_grant), 64'(eg));
        chk("regwrite", 64'(s_rw),    64'(m_rw));
        chk("wreg",     64'(s_wreg),  64'(m_wreg));
        chk("wdata",    64'(s_wdata), 64'(m_wdata));
        chk("busy1",    64'(s_b1),    64'(exp_busy(bus.ReadAddr1)));
        chk("busy2",    64'(s_b2),    64'(exp_busy(bus.ReadAddr2)));
        last_gnt = g;
        @(posedge Clk);
        if (Reset_n) begin
            if (g >= 0) begin
                m_rw    = (ra[g] != '0);
                m_wreg  = ra[g];
                m_wdata = rd[g];
                m_last  = g;
                m_busy[ra[g]] = 1'b0;
            end else begin
                m_rw = 1'b0;
            end
            if (bus.Reserve && (bus.ReserveAddr != '0)) m_busy[bus.ReserveAddr] = 1'b1;
        end
        @(negedge Clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        last_gnt = -1;
        model_reset();
        bus.Req = '0;
        bus.Reserve = 1'b0;
        bus.ReserveAddr = '0;
        bus.ReadAddr1 = '0;
        bus.ReadAddr2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rd[i] = '0;
            waitc[i] = 0;
        end
        @(negedge Clk);
        step();
        chk("init_grant", 64'(s_grant), 64'(3'b000));
        chk("init_rw",    64'(s_rw),    64'(1'b0));
        Reset_n = 1'b1;

        // traffic in flight, then reset mid-stream
        bus.Req = 3'b111;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
        bus.Reserve = 1'b1; bus.ReserveAddr = 5'd3; bus.ReadAddr1 = 5'd3;
        step();
        bus.Reserve = 1'b0;
        step();
        chk("pre_rst_busy1", 64'(s_b1), 64'(1'b1));
        Reset_n = 1'b0;
        step();
        chk("rst_grant", 64'(s_grant), 64'(3'b000));
        chk("rst_rw",    64'(s_rw),    64'(1'b0));
        chk("rst_busy1", 64'(s_b1),    64'(1'b0));
        Reset_n = 1'b1;

        // two requesters held: strict alternation starting at requester 0
        bus.Req = 3'b101;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("alt_grant", 64'(s_grant), (k % 2 == 0) ? 64'(3'b001) : 64'(3'b100));
        end

        // all three held
        bus.Req = 3'b111;
        ra[0] = 5'd5; ra[1] = 5'd6; ra[2] = 5'd7;
        rd[0] = 32'hA; rd[1] = 32'hB; rd[2] = 32'hC;
        step(); chk("rr_g0", 64'(s_grant), 64'(3'b001));
        step(); chk("rr_g1", 64'(s_grant), 64'(3'b010));
        chk("rr_wreg0", 64'(s_wreg), 64'(5'd5)); chk("rr_wdata0", 64'(s_wdata), 64'(32'hA));
        step(); chk("rr_g2", 64'(s_grant), 64'(3'b100));
        chk("rr_wreg1", 64'(s_wreg), 64'(5'd6)); chk("rr_wdata1", 64'(s_wdata), 64'(32'hB));
        step(); chk("rr_g3", 64'(s_grant), 64'(3'b001));
        chk("rr_wreg2", 64'(s_wreg), 64'(5'd7)); chk("rr_wdata2", 64'(s_wdata), 64'(32'hC));
        chk("rr_rw", 64'(s_rw), 64'(1'b1));
        bus.Req = 3'b000;
        step(); chk("rr_rw_last", 64'(s_rw), 64'(1'b1));

        // write to register 0 is accepted but not committed
        bus.Req = 3'b010; ra[1] = 5'd0; rd[1] = 32'hFFFF_FFFF;
        step(); chk("r0_grant", 64'(s_grant), 64'(3'b010));
        bus.Req = 3'b000;
        step(); chk("r0_rw", 64'(s_rw), 64'(1'b0));

        // reserve then write address 9
        bus.ReadAddr1 = 5'd9; bus.Reserve = 1'b1; bus.ReserveAddr = 5'd9;
        step(); chk("b9_before", 64'(s_b1), 64'(1'b0));
        bus.Reserve = 1'b0; bus.Req = 3'b100; ra[2] = 5'd9; rd[2] = 32'h99;
        step(); chk("b9_resv", 64'(s_b1), 64'(1'b1)); chk("b9_grant", 64'(s_grant), 64'(3'b100));
        bus.Req = 3'b000;
        step(); chk("b9_rw", 64'(s_b1), 64'(1'b1)); chk("b9_rw_on", 64'(s_rw), 64'(1'b1));
        step(); chk("b9_clear", 64'(s_b1), 64'(1'b0));

        // reserve and transfer of address 12 on the same edge
        bus.ReadAddr1 = 5'd12; bus.Reserve = 1'b1; bus.ReserveAddr = 5'd12;
        bus.Req = 3'b001; ra[0] = 5'd12; rd[0] = 32'h12;
        step(); chk("b12_grant", 64'(s_grant), 64'(3'b001));
        bus.Reserve = 1'b0; bus.Req = 3'b000;
        step(); chk("b12_a", 64'(s_b1), 64'(1'b1));
        step(); chk("b12_held", 64'(s_b1), 64'(1'b1));
        bus.Req = 3'b001; rd[0] = 32'h1212;
        step(); chk("b12_w2", 64'(s_b1), 64'(1'b1));
        bus.Req = 3'b000;
        step(); chk("b12_commit", 64'(s_b1), 64'(1'b1));
        step(); chk("b12_clear", 64'(s_b1), 64'(1'b0));

        // randomized handshake traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.Req[i] && ($urandom_range(0, 2) != 0)) begin
                    ra[i] = ADDR_W'($urandom_range(0, 31));
                    rd[i] = $urandom;
                    bus.Req[i] = 1'b1;
                end
            end
            bus.Reserve     = ($urandom_range(0, 2) == 0);
            bus.ReserveAddr = ADDR_W'($urandom_range(0, 31));
            bus.ReadAddr1   = ADDR_W'($urandom_range(0, 31));
            bus.ReadAddr2   = ($urandom_range(0, 1) == 0) ? m_wreg : ADDR_W'($urandom_range(0, 31));
            if (c == 1500) Reset_n = 1'b0;
            if (c == 1503) Reset_n = 1'b1;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!Reset_n || (last_gnt == i) || !bus.Req[i]) begin
                    waitc[i] = 0;
                end else begin
                    waitc[i]++;
                    chk("fair_wait", 64'(waitc[i] < NREQ), 64'(1'b1));
                end
            end
            if (last_gnt >= 0) bus.Req[last_gnt] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
